// File: rtl/rib_xbar.sv
// rib_xbar: NM x NS RIB interconnect with fixed/round-robin arbitration, a burst cap and decode-error capture
module rib_xbar #(
    parameter int NM        = 2,
    parameter int NS        = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int SEL_W     = 4,
    parameter int ARB_MODE  = 0,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [NM-1:0]    m_req_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*AW-1:0] m_addr_i,
    input  logic [NM*DW-1:0] m_wdata_i,
    output logic [NM-1:0]    m_gnt_o,
    output logic [NM*DW-1:0] m_rdata_o,
    output logic [NS-1:0]    s_hsel_o,
    output logic [NS-1:0]    s_we_o,
    output logic [AW-1:0]    s_addr_o,
    output logic [DW-1:0]    s_wdata_o,
    input  logic [NS*DW-1:0] s_rdata_i,
    output logic             hold_flag_o,
    output logic [15:0]      err_cnt_o,
    output logic [AW-1:0]    err_addr_o
);
    localparam int IW = $clog2(NM);
    localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t state, state_nx;
    logic [IW-1:0] owner, rr_ptr, win, gidx;
    logic [BW-1:0] burst_cnt;
    logic [NM-1:0] cand;
    logic [SEL_W-1:0] sel;
    logic [DW-1:0] rdata;
    logic owner_req, others, force_rel, keep, win_vld, granted, act, dec_ok;
    always_comb begin
        owner_req = state == OWNED && m_req_i[owner];
        others    = state == OWNED && |(m_req_i & ~(NM'(1) << owner));
        force_rel = MAX_BURST != 0 && burst_cnt == BW'(MAX_BURST) && others;
        keep      = owner_req && !force_rel;
        // The owner never competes in a re-arbitration: it either dropped its request or is being forced out
        cand      = state == OWNED ? m_req_i & ~(NM'(1) << owner) : m_req_i;
        win       = '0;
        win_vld   = 1'b0;
        // Scanning downwards leaves the first requester at/after the start point in win
        for (int i = NM - 1; i >= 0; i--) begin
            if (cand[IW'((ARB_MODE != 0 ? int'(rr_ptr) + i : i) % NM)]) begin
                win     = IW'((ARB_MODE != 0 ? int'(rr_ptr) + i : i) % NM);
                win_vld = 1'b1;
            end
        end
        granted   = keep || win_vld;
        gidx      = keep ? owner : win;
        act       = granted && !nRst;
        state_nx  = granted ? OWNED : IDLE;
        m_gnt_o   = act ? NM'(1) << gidx : '0;
        s_addr_o  = m_addr_i[gidx*AW +: AW];
        s_wdata_o = m_wdata_i[gidx*DW +: DW];
        sel       = s_addr_o[AW-1 -: SEL_W];
        dec_ok    = 32'(sel) < NS;
        s_hsel_o  = act && dec_ok ? NS'(1) << sel : '0;
        s_we_o    = s_hsel_o & {NS{m_we_i[gidx]}};
        rdata     = '0;
        for (int s = 0; s < NS; s++)
            if (s_hsel_o[s]) rdata = s_rdata_i[s*DW +: DW];
        m_rdata_o = '0;
        for (int k = 0; k < NM; k++)
            m_rdata_o[k*DW +: DW] = m_gnt_o[k] ? rdata : '0;
        hold_flag_o = !nRst && |(m_req_i & ~m_gnt_o);
    end
    always_ff @(posedge clk) begin
        if (nRst) begin
            state     <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
            err_cnt_o <= '0;
            err_addr_o <= '0;
        end else begin
            state     <= state_nx;
            owner     <= gidx;
            burst_cnt <= !granted ? '0 : !keep ? BW'(1) :
                         burst_cnt == BW'(MAX_BURST) ? burst_cnt : burst_cnt + 1'b1;
            if (granted && !keep) rr_ptr <= gidx == IW'(NM - 1) ? '0 : gidx + 1'b1;
            if (granted && !dec_ok) begin
                err_cnt_o  <= err_cnt_o + {15'd0, err_cnt_o != 16'hFFFF};
                err_addr_o <= s_addr_o;
            end
        end
    end
endmodule

// File: tb/tb_rib_xbar.sv
// tb_rib_xbar: checks a fixed-priority 2x3 crossbar and a round-robin 3x3 crossbar against a behavioural model
module tb_rib_xbar;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  a_req, a_we, a_gnt;
    logic [63:0] a_addr, a_wdata, a_rdata;
    logic [2:0]  a_hsel, a_swe;
    logic [31:0] a_saddr, a_swdata, a_eaddr;
    logic [95:0] a_srd;
    logic        a_hold;
    logic [15:0] a_ecnt;

    logic [2:0]  b_req, b_we, b_gnt, b_hsel, b_swe;
    logic [95:0] b_addr, b_wdata, b_rdata, b_srd;
    logic [31:0] b_saddr, b_swdata, b_eaddr;
    logic        b_hold;
    logic [15:0] b_ecnt;

    rib_xbar #(.NM(2), .NS(3), .ARB_MODE(0), .MAX_BURST(4)) u_a (
        .clk(clk), .nRst(rst), .m_req_i(a_req), .m_we_i(a_we), .m_addr_i(a_addr),
        .m_wdata_i(a_wdata), .m_gnt_o(a_gnt), .m_rdata_o(a_rdata), .s_hsel_o(a_hsel),
        .s_we_o(a_swe), .s_addr_o(a_saddr), .s_wdata_o(a_swdata), .s_rdata_i(a_srd),
        .hold_flag_o(a_hold), .err_cnt_o(a_ecnt), .err_addr_o(a_eaddr));

    rib_xbar #(.NM(3), .NS(3), .ARB_MODE(1), .MAX_BURST(1)) u_b (
        .clk(clk), .nRst(rst), .m_req_i(b_req), .m_we_i(b_we), .m_addr_i(b_addr),
        .m_wdata_i(b_wdata), .m_gnt_o(b_gnt), .m_rdata_o(b_rdata), .s_hsel_o(b_hsel),
        .s_we_o(b_swe), .s_addr_o(b_saddr), .s_wdata_o(b_swdata), .s_rdata_i(b_srd),
        .hold_flag_o(b_hold), .err_cnt_o(b_ecnt), .err_addr_o(b_eaddr));

    int passed = 0;
    int total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Who holds the bus this cycle, from the arbitration rules alone
    function automatic int pick(input int mode, input int nm, input int maxb, input int own,
                                input int run, input int ptr, input logic [7:0] req);
        logic [7:0] oth;
        oth = req;
        if (own >= 0) oth[own] = 1'b0;
        if (own >= 0 && req[own] && !(maxb != 0 && run >= maxb && oth != 0)) return own;
        for (int i = 0; i < nm; i++) begin
            int j;
            j = mode != 0 ? (ptr + i) % nm : i;
            if (oth[j]) return j;
        end
        return -1;
    endfunction

    int a_own = -1, a_run = 0, a_ptr = 0, an_own = -1, an_run = 0, an_ptr = 0;
    int b_own = -1, b_run = 0, b_ptr = 0, bn_own = -1, bn_run = 0, bn_ptr = 0;
    logic [15:0] m_ecnt = '0, n_ecnt = '0;
    logic [31:0] m_eaddr = '0, n_eaddr = '0;

    always @(negedge clk) begin : cmp
        int g, sel;
        logic [1:0] eg;
        logic [2:0] hs, ebg;
        logic [31:0] addr;
        logic [63:0] rd;
        g = rst ? -1 : pick(0, 2, 4, a_own, a_run, a_ptr, {6'b0, a_req});
        eg = '0; hs = '0; rd = '0; addr = '0; sel = 0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            addr = a_addr[g*32 +: 32];
            sel = int'(addr[31:28]);
            if (sel < 3) begin
                hs[sel] = 1'b1;
                rd[g*32 +: 32] = a_srd[sel*32 +: 32];
            end
            chk("a_saddr", a_saddr, addr);
            chk("a_swdata", a_swdata, a_wdata[g*32 +: 32]);
        end
        chk("a_gnt", a_gnt, eg);
        chk("a_hold", a_hold, !rst && |(a_req & ~eg));
        chk("a_hsel", a_hsel, hs);
        chk("a_swe", a_swe, (g >= 0 && a_we[g]) ? hs : 3'b0);
        chk("a_rdata", a_rdata, rd);
        chk("a_errcnt", a_ecnt, m_ecnt);
        chk("a_erraddr", a_eaddr, m_eaddr);
        an_own = a_own; an_run = a_run; an_ptr = a_ptr; n_ecnt = m_ecnt; n_eaddr = m_eaddr;
        if (rst) begin
            an_own = -1; an_run = 0; an_ptr = 0; n_ecnt = '0; n_eaddr = '0;
        end else begin
            if (g < 0) an_run = 0;
            else if (g == a_own) an_run = a_run + 1;
            else begin an_run = 1; an_ptr = (g + 1) % 2; end
            an_own = g;
            if (g >= 0 && sel >= 3) begin
                n_ecnt = m_ecnt == 16'hFFFF ? m_ecnt : m_ecnt + 16'd1;
                n_eaddr = addr;
            end
        end
        g = rst ? -1 : pick(1, 3, 1, b_own, b_run, b_ptr, {5'b0, b_req});
        ebg = '0;
        if (g >= 0) ebg[g] = 1'b1;
        chk("b_gnt", b_gnt, ebg);
        chk("b_hold", b_hold, !rst && |(b_req & ~ebg));
        bn_own = b_own; bn_run = b_run; bn_ptr = b_ptr;
        if (rst) begin
            bn_own = -1; bn_run = 0; bn_ptr = 0;
        end else begin
            if (g < 0) bn_run = 0;
            else if (g == b_own) bn_run = b_run + 1;
            else begin bn_run = 1; bn_ptr = (g + 1) % 3; end
            bn_own = g;
        end
    end

    always @(posedge clk) begin
        a_own <= an_own; a_run <= an_run; a_ptr <= an_ptr;
        b_own <= bn_own; b_run <= bn_run; b_ptr <= bn_ptr;
        m_ecnt <= n_ecnt; m_eaddr <= n_eaddr;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(negedge rst);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_order", b_gnt, 64'd1 << (i % 3));
        end
    end

    initial begin
        a_req = 2'b11; a_we = '0; a_wdata = '0;
        a_addr = {32'h0000_0010, 32'h0000_0010};
        a_srd = {32'h3000_0003, 32'h2000_0002, 32'h1000_0001};
        b_req = 3'b111; b_we = '0; b_addr = '0; b_wdata = '0;
        b_srd = {32'hC000_000C, 32'hB000_000B, 32'hA000_000A};
        @(negedge clk);
        chk("rst_gnt", a_gnt, 0);
        chk("rst_hold", a_hold, 0);
        step;
        step;
        rst = 1'b0;
        @(negedge clk);
        chk("t1_gnt", a_gnt, 2'b01);
        chk("t1_hsel", a_hsel, 3'b001);
        chk("t1_hold", a_hold, 1);
        step;
        a_req = 2'b10;
        @(negedge clk);
        chk("t1_drop_gnt", a_gnt, 2'b10);
        step;
        a_req = 2'b00;
        step;
        a_req = 2'b11;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("t3_burst_gnt", a_gnt, 64'd1 << ((c / 4) % 2));
            step;
        end
        a_req = 2'b01;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t3_solo_gnt", a_gnt, 2'b01);
            step;
        end
        a_req = 2'b00;
        step;
        a_req = 2'b01; a_we = 2'b01;
        a_addr[31:0] = 32'h2000_0004; a_wdata[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t4_swe", a_swe, 3'b100);
        chk("t4_swdata", a_swdata, 32'hDEAD_BEEF);
        chk("t4_hsel", a_hsel, 3'b100);
        step;
        a_we = 2'b00;
        @(negedge clk);
        chk("t4_rdata", a_rdata, 64'h0000_0000_3000_0003);
        chk("t4_swe_rd", a_swe, 3'b000);
        step;
        a_req = 2'b00;
        step;
        a_req = 2'b10; a_addr[63:32] = 32'hF000_0000;
        @(negedge clk);
        chk("t5_errcnt0", a_ecnt, 16'd0);
        chk("t5_hsel", a_hsel, 3'b000);
        chk("t5_rdata", a_rdata, 64'd0);
        step;
        step;
        a_req = 2'b00;
        @(negedge clk);
        chk("t5_errcnt", a_ecnt, 16'd2);
        chk("t5_erraddr", a_eaddr, 32'hF000_0000);
        step;
        a_req = 2'b10;
        repeat (65540) step;
        a_req = 2'b00;
        @(negedge clk);
        chk("t5_errsat", a_ecnt, 16'hFFFF);
        step;
        a_req = 2'b01; a_addr[31:0] = 32'h0000_0010;
        step;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_gnt", a_gnt, 2'b00);
        chk("t6_hold", a_hold, 0);
        step;
        rst = 1'b0; a_req = 2'b10;
        @(negedge clk);
        chk("t6_first_gnt", a_gnt, 2'b10);
        chk("t6_errcnt", a_ecnt, 16'd0);
        step;
        a_req = 2'b00;
        repeat (3) step;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
